vproc_div_seq: RTL and testbench
================================

VPROC_DIV_SEQ -- requirements
Module: vproc_div_seq

Interface
REQ-001 SHALL have parameter DIV_LAT, default 1, cycles from div_op*_o to the matching div_res_i (legal 0..2).
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port async_rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid_i  input  1  request valid.
REQ-005 SHALL have port in_ready_o  output  1  request accepted when in_valid_i & in_ready_o.
REQ-006 SHALL have port in_op1_i / in_op2_i  input  32 each  packed dividend / divisor elements.
REQ-007 SHALL have port in_ew_i  input  2  element width (vproc_pkg::div_ew_e: 8/16/32 bit).
REQ-008 SHALL have port in_signed_i  input  1  signed elements.
REQ-009 SHALL have port in_mod_i  input  1  0 = quotient, 1 = remainder.
REQ-010 SHALL have port div_valid_o  output  1  lane issued to divider this cycle.
REQ-011 SHALL have port div_op1_o / div_op2_o  output  32 each  extended lane operands.
REQ-012 SHALL have ports div_mod_o and div_signed_o  output  1 each  divider mode and signedness.
REQ-013 SHALL have port div_res_i  input  32  divider result, DIV_LAT cycles after issue.
REQ-014 SHALL have ports out_valid_o  output  1, out_ready_i  input  1, out_res_o  output  32 (packed result).

Function
REQ-015 SHALL split the request into N lanes (N = 4/2/1 for ew 8/16/32), lane 0 at bit 0.
REQ-016 SHALL sign-extend lanes when in_signed_i=1, else zero-extend, to 32 bits on div_op*_o.
REQ-017 SHALL use states IDLE, RUN, WAIT, DONE; in_ready_o=1 only in IDLE.
REQ-018 SHALL go IDLE->RUN on accept and latch operands, ew, signed and mod.
REQ-019 SHALL issue one lane per RUN cycle, in lane order, with div_valid_o=1; go RUN->WAIT after lane N-1, or RUN->DONE directly if DIV_LAT=0.
REQ-020 SHALL track in-flight lanes with a DIV_LAT-deep valid/index shift register and write div_res_i, truncated to ew, into that lane of the result register.
REQ-021 SHALL go WAIT->DONE in the cycle the last lane result is written.
REQ-022 SHALL assert out_valid_o for exactly DONE; out_valid_o first rises N+DIV_LAT+1 cycles after the accept edge.
REQ-023 SHALL hold out_res_o stable while out_valid_o=1 and out_ready_i=0; DONE->IDLE on handshake.
REQ-024 SHALL drive div_valid_o=0 and div_op*_o=0 outside RUN.
REQ-025 SHALL rely on truncation for per-lane RISC-V corner cases (x/0 -> all-ones, x%0 -> x, MIN/-1 -> MIN, MIN%-1 -> 0).

Reset
REQ-026 SHALL, on async_rst_ni=0, force IDLE, in_ready_o=1, out_valid_o=0, div_valid_o=0, out_res_o=0, shift register cleared.
REQ-027 SHALL abandon a request in progress on reset; divider results still arriving after reset are ignored.

Configuration
REQ-028 SHALL, with VPROC_DIV_SEQ_DZ_FLAG_EN defined, add output out_dz_o (1 bit), valid with out_valid_o, set if any lane divisor was zero, reset 0.
REQ-029 SHALL, without VPROC_DIV_SEQ_DZ_FLAG_EN, have no out_dz_o port and no related logic.

Structure
REQ-030 SHALL take the div_ew_e enum and a lane-count function from vproc_pkg.
REQ-031 SHALL contain no sub-modules; the divider stays external and is connected by the parent.

Verification
REQ-032 ew8 signed div, op1=0x800AF607, op2=0xFF030200 -> out_res_o=0x8003FBFF, out_dz_o=1.
REQ-033 ew16 unsigned rem, op1=0xFFFF0064, op2=0x00100007 -> out_res_o=0x000F0002.
REQ-034 ew32 unsigned div, op1=0xFFFFFFFE, op2=0x00000002 -> div_signed_o=0, out_res_o=0x7FFFFFFF.
REQ-035 DIV_LAT=2, ew8, accept at cycle T -> div_valid_o high T+1..T+4, out_valid_o rises at T+7.
REQ-036 out_ready_i=0 for 5 cycles in DONE -> out_valid_o=1, out_res_o constant, in_ready_o=0; handshake -> in_ready_o=1 next cycle.
REQ-037 reset asserted in RUN -> out_valid_o=0 and in_ready_o=1 immediately; next request completes correctly.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector divide sequencer.
package vproc_pkg;

    // Element width of a packed divide request.
    typedef enum logic [1:0] {
        DIV_EW8  = 2'd0,
        DIV_EW16 = 2'd1,
        DIV_EW32 = 2'd2
    } div_ew_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_RUN  = 2'd1,
        DS_WAIT = 2'd2,
        DS_DONE = 2'd3
    } div_state_e;

    // Number of lanes packed into one 32-bit word.
    function automatic logic [2:0] div_lanes(input div_ew_e ew);
        logic [2:0] n;
        case (ew)
            DIV_EW8:  n = 3'd4;
            DIV_EW16: n = 3'd2;
            default:  n = 3'd1;
        endcase
        return n;
    endfunction

    // Extract lane idx of a packed word and widen it to 32 bits.
    function automatic logic [31:0] div_lane_ext(input logic [31:0] word,
                                                 input logic [1:0]  idx,
                                                 input div_ew_e     ew,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ext;
        case (ew)
            DIV_EW8: begin
                b   = word[{idx, 3'b000} +: 8];
                ext = {{24{sgn & b[7]}}, b};
            end
            DIV_EW16: begin
                h   = word[{idx[0], 4'b0000} +: 16];
                ext = {{16{sgn & h[15]}}, h};
            end
            default: ext = word;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/vproc_div_seq.sv
// Vector divide sequencer: splits a packed 32-bit request into 8/16/32-bit
// lanes, issues them one per cycle to an external 32-bit divider with fixed
// latency DIV_LAT (0..2), and reassembles the truncated lane results.
// Optional: define VPROC_DIV_SEQ_DZ_FLAG_EN to add out_dz_o, which flags
// that at least one lane divisor of the request was zero.
//
// state | meaning
// IDLE  | waiting for a request, in_ready_o high
// RUN   | issuing one lane per cycle to the divider
// WAIT  | all lanes issued, waiting for the last result
// DONE  | packed result valid, waiting for out_ready_i
module vproc_div_seq
    import vproc_pkg::*;
#(
    parameter int unsigned DIV_LAT = 1
) (
    input  logic        clk_i,
    input  logic        async_rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_op1_i,
    input  logic [31:0] in_op2_i,
    input  div_ew_e     in_ew_i,
    input  logic        in_signed_i,
    input  logic        in_mod_i,
    output logic        div_valid_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_mod_o,
    output logic        div_signed_o,
    input  logic [31:0] div_res_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_res_o
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    ,
    output logic        out_dz_o
`endif
);

    div_state_e  state_q, state_d;
    logic [31:0] op1_q, op2_q, res_q, res_d;
    div_ew_e     ew_q;
    logic        sgn_q, mod_q;
    logic [1:0]  lane_q;
    logic [2:0]  n_lanes;
    logic        accept, issue, last_issue;
    logic        res_vld, last_wr;
    logic [1:0]  res_idx;
    logic [31:0] lane_op1, lane_op2;

    assign n_lanes    = div_lanes(ew_q);
    assign accept     = in_valid_i && (state_q == DS_IDLE);
    assign issue      = (state_q == DS_RUN);
    assign last_issue = ({1'b0, lane_q} == (n_lanes - 3'd1));
    assign lane_op1   = div_lane_ext(op1_q, lane_q, ew_q, sgn_q);
    assign lane_op2   = div_lane_ext(op2_q, lane_q, ew_q, sgn_q);
    assign last_wr    = res_vld && ({1'b0, res_idx} == (n_lanes - 3'd1));

    // In-flight lane tracking: with zero latency the result belongs to the
    // lane being issued right now, otherwise it trails by DIV_LAT cycles.
    if (DIV_LAT == 0) begin : g_lat0
        assign res_vld = issue;
        assign res_idx = lane_q;
    end else begin : g_pipe
        logic [DIV_LAT-1:0] vld_q;
        logic [1:0]         idx_q [DIV_LAT];

        // Shift issued lane index along with the divider latency.
        always_ff @(posedge clk_i or negedge async_rst_ni) begin
            if (!async_rst_ni) begin
                vld_q <= '0;
                for (int i = 0; i < int'(DIV_LAT); i++) idx_q[i] <= 2'd0;
            end else begin
                vld_q[0] <= issue;
                idx_q[0] <= lane_q;
                for (int i = 1; i < int'(DIV_LAT); i++) begin
                    vld_q[i] <= vld_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end
        end

        assign res_vld = vld_q[DIV_LAT-1];
        assign res_idx = idx_q[DIV_LAT-1];
    end

    // Merge the returning lane result, truncated to element width.
    always_comb begin
        res_d = res_q;
        if (res_vld) begin
            case (ew_q)
                DIV_EW8:  res_d[{res_idx, 3'b000} +: 8]     = div_res_i[7:0];
                DIV_EW16: res_d[{res_idx[0], 4'b0000} +: 16] = div_res_i[15:0];
                default:  res_d = div_res_i;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) state_q <= DS_IDLE;
        else               state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (in_valid_i)  state_d = DS_RUN;
            DS_RUN:  if (last_issue)  state_d = (DIV_LAT == 0) ? DS_DONE : DS_WAIT;
            DS_WAIT: if (last_wr)     state_d = DS_DONE;
            DS_DONE: if (out_ready_i) state_d = DS_IDLE;
            default:                  state_d = DS_IDLE;
        endcase
    end

    // Outputs decoded from state; lane operands are forced to zero when idle.
    always_comb begin
        in_ready_o   = (state_q == DS_IDLE);
        out_valid_o  = (state_q == DS_DONE);
        div_valid_o  = issue;
        div_op1_o    = issue ? lane_op1 : 32'd0;
        div_op2_o    = issue ? lane_op2 : 32'd0;
        div_mod_o    = mod_q;
        div_signed_o = sgn_q;
    end

    // Request latch, lane counter and result register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            op1_q  <= '0;
            op2_q  <= '0;
            ew_q   <= DIV_EW8;
            sgn_q  <= 1'b0;
            mod_q  <= 1'b0;
            lane_q <= 2'd0;
            res_q  <= '0;
        end else if (accept) begin
            op1_q  <= in_op1_i;
            op2_q  <= in_op2_i;
            ew_q   <= in_ew_i;
            sgn_q  <= in_signed_i;
            mod_q  <= in_mod_i;
            lane_q <= 2'd0;
            res_q  <= '0;
        end else begin
            if (issue) lane_q <= lane_q + 2'd1;
            res_q <= res_d;
        end
    end

    assign out_res_o = res_q;

`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    logic dz_q;

    // Sticky zero-divisor flag, cleared when a new request is accepted.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni)                   dz_q <= 1'b0;
        else if (accept)                     dz_q <= 1'b0;
        else if (issue && lane_op2 == 32'd0) dz_q <= 1'b1;
    end

    assign out_dz_o = dz_q;
`endif

endmodule

// File: tb/tb_vproc_div_seq.sv
// Bench for vproc_div_seq: one instance with DIV_LAT=0 and one with
// DIV_LAT=2 are driven in lockstep, each backed by a behavioural divider.
module tb_vproc_div_seq;
    import vproc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [31:0] op1, op2;
    div_ew_e     ew;
    logic        sgn, mdo;
    logic        out_ready;

    logic        rdy0, dv0, dmod0, dsgn0, ov0;
    logic [31:0] dop1_0, dop2_0, dres0, res0;
    logic        rdy2, dv2, dmod2, dsgn2, ov2;
    logic [31:0] dop1_2, dop2_2, dres2, res2;
    logic [31:0] p1, p2;
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
    logic        dz0, dz2;
`endif

    vproc_div_seq #(.DIV_LAT(0)) u_dut0 (
        .clk_i(clk), .async_rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_op1_i(op1), .in_op2_i(op2), .in_ew_i(ew),
        .in_signed_i(sgn), .in_mod_i(mdo),
        .div_valid_o(dv0), .div_op1_o(dop1_0), .div_op2_o(dop2_0),
        .div_mod_o(dmod0), .div_signed_o(dsgn0), .div_res_i(dres0),
        .out_valid_o(ov0), .out_ready_i(out_ready), .out_res_o(res0)
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
        , .out_dz_o(dz0)
`endif
    );

    vproc_div_seq #(.DIV_LAT(2)) u_dut2 (
        .clk_i(clk), .async_rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(rdy2),
        .in_op1_i(op1), .in_op2_i(op2), .in_ew_i(ew),
        .in_signed_i(sgn), .in_mod_i(mdo),
        .div_valid_o(dv2), .div_op1_o(dop1_2), .div_op2_o(dop2_2),
        .div_mod_o(dmod2), .div_signed_o(dsgn2), .div_res_i(dres2),
        .out_valid_o(ov2), .out_ready_i(out_ready), .out_res_o(res2)
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
        , .out_dz_o(dz2)
`endif
    );

    // RISC-V style 32-bit divider behaviour.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s, input logic m);
        if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'd0 : a;
        if (s) return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return m ? (a % b) : (a / b);
    endfunction

    assign dres0 = div_model(dop1_0, dop2_0, dsgn0, dmod0);

    always_ff @(posedge clk) begin
        p1 <= div_model(dop1_2, dop2_2, dsgn2, dmod2);
        p2 <= p1;
    end
    assign dres2 = p2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        div_ew_e     ew;
        logic        s;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          n;
        logic [31:0] op1_k2;   // dut2 div_op1_o in the second cycle after accept
    } vec_t;

    vec_t vecs[8];

    task automatic start_req(input vec_t v);
        @(negedge clk);
        op1 = v.a; op2 = v.b; ew = v.ew; sgn = v.s; mdo = v.m;
        in_valid = 1'b1;
        check("ready_before_accept", {30'd0, rdy0, rdy2}, 32'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string name, input bit trail);
        int  k, dv_first, dv_cnt;
        bit  got0, got2;
        k = 0; dv_first = 0; dv_cnt = 0; got0 = 0; got2 = 0;
        start_req(v);
        while (!(got0 && got2) && k < 40) begin
            @(negedge clk);
            k++;
            if (dv2) begin
                dv_cnt++;
                if (dv_first == 0) dv_first = k;
            end
            if (k == 1) check({name, "_sign_mode"}, {30'd0, dsgn2, dmod2}, {30'd0, v.s, v.m});
            if (k == 2) check({name, "_op1_k2"}, dop1_2, v.op1_k2);
            if (ov0 && !got0) begin
                got0 = 1;
                check({name, "_lat0"}, k, v.n + 1);
                check({name, "_res0"}, res0, v.res);
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
                check({name, "_dz0"}, {31'd0, dz0}, {31'd0, v.dz});
`endif
            end
            if (ov2 && !got2) begin
                got2 = 1;
                check({name, "_lat2"}, k, v.n + 3);
                check({name, "_res2"}, res2, v.res);
                check({name, "_idle_div"}, {dop1_2[30:0], dv2} | dop2_2, 32'd0);
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
                check({name, "_dz2"}, {31'd0, dz2}, {31'd0, v.dz});
`endif
            end
        end
        check({name, "_done_seen"}, {30'd0, got0, got2}, 32'd3);
        check({name, "_dv_first"}, dv_first, 1);
        check({name, "_dv_count"}, dv_cnt, v.n);
        if (trail) begin
            @(negedge clk);
            check({name, "_ready_after"}, {29'd0, rdy0, rdy2, ov2}, 32'd6);
        end
    endtask

    initial begin
        vecs[0] = '{DIV_EW8,  1'b1, 1'b0, 32'h800AF607, 32'hFF030200, 32'h8003FBFF, 1'b1, 4, 32'hFFFFFFF6};
        vecs[1] = '{DIV_EW16, 1'b0, 1'b1, 32'hFFFF0064, 32'h00100007, 32'h000F0002, 1'b0, 2, 32'h0000FFFF};
        vecs[2] = '{DIV_EW32, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF, 1'b0, 1, 32'h00000000};
        vecs[3] = '{DIV_EW32, 1'b1, 1'b0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1, 32'h00000000};
        vecs[4] = '{DIV_EW32, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 32'h00000000};
        vecs[5] = '{DIV_EW16, 1'b1, 1'b1, 32'hFFF90011, 32'h00030005, 32'hFFFF0002, 1'b0, 2, 32'hFFFFFFF9};
        vecs[6] = '{DIV_EW8,  1'b0, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 4, 32'h00000056};
        vecs[7] = '{DIV_EW8,  1'b0, 1'b0, 32'hFF804010, 32'h0F020404, 32'h11401004, 1'b0, 4, 32'h00000040};

        rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; ew = DIV_EW8;
        sgn = 1'b0; mdo = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready_valid", {28'd0, rdy0, rdy2, ov0, ov2}, 32'hC);
        check("rst_res", res0 | res2, 32'd0);
        check("rst_div_valid", {30'd0, dv0, dv2}, 32'd0);
`ifdef VPROC_DIV_SEQ_DZ_FLAG_EN
        check("rst_dz", {30'd0, dz0, dz2}, 32'd0);
`endif
        rst_n = 1'b1;

        run_txn(vecs[0], "ew8_sdiv", 1'b1);
        run_txn(vecs[1], "ew16_urem", 1'b1);
        run_txn(vecs[2], "ew32_udiv", 1'b1);
        run_txn(vecs[3], "ew32_div0", 1'b1);
        run_txn(vecs[4], "ew32_ovf", 1'b1);
        run_txn(vecs[5], "ew16_srem", 1'b1);
        run_txn(vecs[6], "ew8_rem0", 1'b1);
        run_txn(vecs[7], "ew8_udiv", 1'b1);

        // Backpressure in DONE.
        out_ready = 1'b0;
        run_txn(vecs[7], "stall", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {29'd0, ov2, ov0, rdy2}, 32'd6);
            check("stall_res", res2, 32'h11401004);
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release", {29'd0, rdy2, rdy0, ov2}, 32'd6);

        // Reset in the middle of RUN.
        start_req(vecs[0]);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {30'd0, rdy2, dv2}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {28'd0, ov2, rdy2, ov0, rdy0}, 32'h5);
        check("mid_rst_res", res2 | res0, 32'd0);
        check("mid_rst_div", {30'd0, dv2, dv0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_quiet", {29'd0, ov2, rdy2, dv2}, 32'd2);
        run_txn(vecs[5], "after_rst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
